// File: rtl/dma_mem_responder_if.sv
// Read/write request bus between a DMA channel (master) and its memory responder (slave).
interface dma_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;

    modport master (
        output rd_addr, rd_valid, wr_addr, wr_data, wr_valid,
        input  rd_ready, rd_data, wr_ready
    );

    modport slave (
        input  rd_addr, rd_valid, wr_addr, wr_data, wr_valid,
        output rd_ready, rd_data, wr_ready
    );
endinterface

// File: rtl/dma_mem_responder.sv
// Memory-side responder for a DMA channel: word memory behind a 2-entry write FIFO,
// latency-programmable read FSM with read-after-write ordering, range checks and counters.
module dma_mem_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    MEM_DEPTH    = 256,
    parameter int                    READ_LATENCY = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dma_mem_responder_if.slave    bus,
    input  logic                  err_clr,
    output logic                  err_sticky,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int AL  = $clog2(BPW);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam int CW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        addr_bad = (a < BASE_ADDR) ||
                   ((a & ADDR_WIDTH'(BPW - 1)) != '0) ||
                   ((off >> AL) >= ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] word;
        word = (a - BASE_ADDR) >> AL;
        addr_idx = word[IW-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    rd_state_t             state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [IW-1:0]         rd_idx_reg;
    logic                  rd_bad_reg;
    logic                  rd_ready_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [15:0]           rd_count_reg;
    logic [15:0]           wr_count_reg;
    logic                  err_sticky_reg;
    logic [ADDR_WIDTH-1:0] err_addr_reg;

    logic [IW-1:0]         fifo_idx_reg  [2];
    logic [DATA_WIDTH-1:0] fifo_data_reg [2];
    logic                  fifo_wptr_reg;
    logic                  fifo_rptr_reg;
    logic [1:0]            fifo_count_reg;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  read_hold;
    logic                  wr_ready_int;
    logic                  wr_fire;
    logic                  wr_bad;
    logic                  push;
    logic                  pop;
    logic                  rd_req;
    logic                  rd_bad_now;
    logic                  rd_err;
    logic                  wr_err;

    assign fifo_empty   = (fifo_count_reg == 2'd0);
    assign fifo_full    = (fifo_count_reg == 2'd2);
    // A read that is due to sample must not be starved by a stream of new writes.
    assign read_hold    = (state_reg == R_WAIT) && (cnt_reg == '0);
    assign wr_ready_int = !fifo_full && !read_hold;
    assign wr_fire      = bus.wr_valid && wr_ready_int;
    assign wr_bad       = addr_bad(bus.wr_addr);
    assign push         = wr_fire && !wr_bad;
    assign pop          = !fifo_empty;
    assign rd_req       = (state_reg == R_IDLE) && bus.rd_valid;
    assign rd_bad_now   = addr_bad(bus.rd_addr);
    assign rd_err       = rd_req && rd_bad_now;
    assign wr_err       = wr_fire && wr_bad;

    assign bus.wr_ready = wr_ready_int;
    assign bus.rd_ready = rd_ready_reg;
    assign bus.rd_data  = rd_data_reg;
    assign rd_count     = rd_count_reg;
    assign wr_count     = wr_count_reg;
    assign err_sticky   = err_sticky_reg;
    assign err_addr     = err_addr_reg;

    // Storage arrays carry no reset so they map onto RAM/distributed memory.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_reg[fifo_wptr_reg]  <= addr_idx(bus.wr_addr);
            fifo_data_reg[fifo_wptr_reg] <= bus.wr_data;
        end
        if (pop) begin
            mem[fifo_idx_reg[fifo_rptr_reg]] <= fifo_data_reg[fifo_rptr_reg];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wptr_reg  <= 1'b0;
            fifo_rptr_reg  <= 1'b0;
            fifo_count_reg <= 2'd0;
            wr_count_reg   <= 16'd0;
        end else begin
            if (push) fifo_wptr_reg <= ~fifo_wptr_reg;
            if (pop)  fifo_rptr_reg <= ~fifo_rptr_reg;
            fifo_count_reg <= fifo_count_reg + 2'(push) - 2'(pop);
            if (wr_fire) wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= R_IDLE;
            cnt_reg      <= '0;
            rd_idx_reg   <= '0;
            rd_bad_reg   <= 1'b0;
            rd_ready_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_count_reg <= 16'd0;
        end else begin
            rd_ready_reg <= 1'b0;
            rd_data_reg  <= '0;
            case (state_reg)
                R_IDLE: begin
                    if (bus.rd_valid) begin
                        rd_idx_reg <= addr_idx(bus.rd_addr);
                        rd_bad_reg <= rd_bad_now;
                        cnt_reg    <= CW'(READ_LATENCY - 1);
                        state_reg  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end else if (fifo_empty) begin
                        rd_data_reg  <= rd_bad_reg ? '0 : mem[rd_idx_reg];
                        rd_ready_reg <= 1'b1;
                        state_reg    <= R_RESP;
                    end
                end
                R_RESP: begin
                    // A dropped request here is a protocol violation: abort uncounted.
                    if (bus.rd_valid) rd_count_reg <= rd_count_reg + 16'd1;
                    state_reg <= R_IDLE;
                end
                default: state_reg <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_reg <= 1'b0;
            err_addr_reg   <= '0;
        end else if (rd_err || wr_err) begin
            err_sticky_reg <= 1'b1;
            if (!err_sticky_reg || err_clr)
                err_addr_reg <= rd_err ? bus.rd_addr : bus.wr_addr;
        end else if (err_clr) begin
            err_sticky_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dma_mem_responder.sv
// Scoreboard bench for dma_mem_responder: expected read data queued at request time,
// popped and compared whenever the responder strobes rd_ready.
module tb_dma_mem_responder;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err_clr = 1'b0;
    logic          err_sticky;
    logic [AW-1:0] err_addr;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];

    dma_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dma_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
        .READ_LATENCY(2), .BASE_ADDR(32'h1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr),
        .err_sticky(err_sticky), .err_addr(err_addr),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every response strobe consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rd_ready) begin
            check_value("rd_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                $display("rd resp data=%h", bus.rd_data);
                check_value("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    // Called aligned just after a rising edge; returns aligned just after a rising edge.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] want, output int lat);
        bus.rd_addr  = a;
        bus.rd_valid = 1'b1;
        exp_q.push_back(want);
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.rd_ready) break;
            check_value("rd_data_zero_idle", bus.rd_data, 64'd0);
            lat++;
            if (lat > 20) begin
                check_value("rd_timeout", 64'(bus.rd_ready), 64'd1);
                exp_q.delete();
                break;
            end
        end
        tick();
        bus.rd_valid = 1'b0;
        $display("rd req addr=%h latency=%0d", a, lat);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit stalled);
        int waited;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        stalled = 1'b0;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.wr_ready) break;
            stalled = 1'b1;
            waited++;
            if (waited > 20) begin
                check_value("wr_timeout", 64'(bus.wr_ready), 64'd1);
                break;
            end
        end
        tick();
        bus.wr_valid = 1'b0;
        $display("wr addr=%h data=%h stalled=%0d", a, d, stalled);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          st;
        bit          st_any;
        logic [15:0] rc0;
        logic [15:0] wc0;

        bus.rd_addr = '0; bus.rd_valid = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
        check_value("rst_rd_data", bus.rd_data, 64'd0);
        check_value("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
        check_value("rst_err_sticky", 64'(err_sticky), 64'd0);
        check_value("rst_err_addr", 64'(err_addr), 64'd0);
        check_value("rst_counts", {32'd0, rd_count, wr_count}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic write, idle, then read with the no-backlog latency.
        do_write(32'h1008, 64'hDEADBEEF_CAFEF00D, st);
        repeat (3) tick();
        do_read(32'h1008, 64'hDEADBEEF_CAFEF00D, lat);
        check_value("t1_latency", 64'(lat), 64'd3);
        check_value("t1_rd_count", 64'(rd_count), 64'd1);
        check_value("t1_wr_count", 64'(wr_count), 64'd1);

        // Read issued the cycle right after the write must see the new data.
        do_write(32'h1010, 64'h1111, st);
        do_read(32'h1010, 64'h1111, lat);

        // Read racing a write burst: writes must stall, read sees the second write.
        st_any = 1'b0;
        fork
            begin
                do_write(32'h1020, 64'hA0A0_0000_0000_0001, st); st_any |= st;
                do_write(32'h1028, 64'hA0A0_0000_0000_0002, st); st_any |= st;
                do_write(32'h1030, 64'hA0A0_0000_0000_0003, st); st_any |= st;
                do_write(32'h1038, 64'hA0A0_0000_0000_0004, st); st_any |= st;
            end
            do_read(32'h1028, 64'hA0A0_0000_0000_0002, lat);
        join
        check_value("t3_wr_stalled", 64'(st_any), 64'd1);
        repeat (2) tick();
        do_read(32'h1020, 64'hA0A0_0000_0000_0001, lat);
        do_read(32'h1030, 64'hA0A0_0000_0000_0003, lat);
        do_read(32'h1038, 64'hA0A0_0000_0000_0004, lat);

        // Address errors: out-of-range read, misaligned write, clear, clear racing a new error.
        do_write(32'h1000, 64'h5555_AAAA_5555_AAAA, st);
        do_read(32'h2000, 64'd0, lat);
        check_value("t4_sticky_set", 64'(err_sticky), 64'd1);
        check_value("t4_err_addr", 64'(err_addr), 64'h2000);
        wc0 = wr_count;
        do_write(32'h1004, 64'h1234_5678_9ABC_DEF0, st);
        check_value("t4_err_addr_kept", 64'(err_addr), 64'h2000);
        check_value("t4_bad_wr_counted", 64'(wr_count), 64'(wc0 + 16'd1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_value("t4_sticky_clr", 64'(err_sticky), 64'd0);
        do_read(32'h1000, 64'h5555_AAAA_5555_AAAA, lat);
        check_value("t4_good_no_err", 64'(err_sticky), 64'd0);
        do_read(32'h0FF8, 64'd0, lat);
        check_value("t4_low_err_addr", 64'(err_addr), 64'h0FF8);
        err_clr = 1'b1;
        do_write(32'h1001, 64'hFFFF, st);
        err_clr = 1'b0;
        check_value("t4_clr_race_sticky", 64'(err_sticky), 64'd1);
        check_value("t4_clr_race_addr", 64'(err_addr), 64'h1001);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Counter wrap: 65536 back-to-back writes bring wr_count back to its start.
        wc0 = wr_count;
        bus.wr_addr  = 32'h1040;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.wr_data = 64'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        $display("wr burst addr=1040 count=65536");
        check_value("t5_wr_wrap", 64'(wr_count), 64'(wc0));
        repeat (2) tick();
        do_read(32'h1040, 64'd65535, lat);

        // Request withdrawn while the response is on the bus: data strobes, no count.
        rc0 = rd_count;
        bus.rd_addr  = 32'h1010;
        bus.rd_valid = 1'b1;
        exp_q.push_back(64'h1111);
        repeat (3) tick();
        bus.rd_valid = 1'b0;
        repeat (2) tick();
        check_value("t5_abort_no_count", 64'(rd_count), 64'(rc0));
        do_read(32'h1008, 64'hDEADBEEF_CAFEF00D, lat);
        check_value("t5_idle_after_abort", 64'(lat), 64'd3);
        check_value("t5_count_after", 64'(rd_count), 64'(rc0 + 16'd1));

        // Asynchronous reset mid-read with a write in the FIFO.
        bus.rd_addr  = 32'h1008;
        bus.rd_valid = 1'b1;
        bus.wr_addr  = 32'h17F8;
        bus.wr_data  = 64'h7777;
        bus.wr_valid = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        bus.rd_valid = 1'b0;
        bus.wr_valid = 1'b0;
        check_value("t6_rd_ready", 64'(bus.rd_ready), 64'd0);
        check_value("t6_rd_data", bus.rd_data, 64'd0);
        check_value("t6_counts", {32'd0, rd_count, wr_count}, 64'd0);
        check_value("t6_wr_ready", 64'(bus.wr_ready), 64'd1);
        check_value("t6_err_sticky", 64'(err_sticky), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'h1008, 64'hDEADBEEF_CAFEF00D, lat);
        check_value("t6_latency", 64'(lat), 64'd3);
        check_value("t6_rd_count", 64'(rd_count), 64'd1);

        repeat (2) tick();
        check_value("q_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
